// File: rtl/nms_row_scheduler.sv
// Row scheduler for the Canny NMS stage.
// Walks a full IMG_W x IMG_H gradient image one column per cycle, streams the
// three magnitude rows into the NMS unit, realigns the angle with the NMS
// window, and writes the suppressed result (zeroed on the border) back out.
// The NMS unit has no load-state return except reset, so it is cleared for
// one cycle between rows.
module nms_row_scheduler #(
    parameter int BIT_LENGTH = 5,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_row,
    output logic [ADDR_W-1:0]     rd_col,
    input  logic [BIT_LENGTH-1:0] mag_up,
    input  logic [BIT_LENGTH-1:0] mag_mid,
    input  logic [BIT_LENGTH-1:0] mag_dn,
    input  logic [1:0]            ang_mid,
    output logic                  nm_enable,
    output logic [BIT_LENGTH-1:0] nm_pixel0,
    output logic [BIT_LENGTH-1:0] nm_pixel1,
    output logic [BIT_LENGTH-1:0] nm_pixel2,
    output logic [1:0]            nm_angle,
    output logic                  nm_clear,
    input  logic [BIT_LENGTH-1:0] nm_pixel_out,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_row,
    output logic [ADDR_W-1:0]     wr_col,
    output logic [BIT_LENGTH-1:0] wr_data
);

    // Cycle-in-state counter must reach IMG_W+3 (last write of a row).
    localparam int CNT_W = $clog2(IMG_W + 4);

    localparam logic [CNT_W-1:0]  T_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  T_WR0     = CNT_W'(4);
    localparam logic [CNT_W-1:0]  T_LASTCOL = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0]  T_W       = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0]  T_ROWEND  = CNT_W'(IMG_W + 3);
    localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] ROW_BOT   = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(IMG_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TOP, S_ROW, S_CLEAR, S_BOT, S_FIN
    } state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_row;
    logic [CNT_W-1:0]    r_t;
    logic [1:0]          r_ang;
    logic                r_clr;

    logic                w_nm_win;
    logic [ADDR_W-1:0]   w_tcol;
    logic [ADDR_W-1:0]   w_wcol;
    logic                w_border;

    // Column currently being read (TOP/BOT/ROW reads) and column being
    // written in ROW, which trails the read by the 4-cycle NMS path.
    assign w_tcol   = ADDR_W'(r_t);
    assign w_wcol   = ADDR_W'(r_t - T_WR0);
    assign w_border = (w_wcol == '0) || (w_wcol == COL_LAST);
    // Gradient data returns one cycle after the read, so the NMS feed
    // window is t=1..IMG_W.
    assign w_nm_win = (r_state == S_ROW) && (r_t >= T_ONE) && (r_t <= T_W);

    assign nm_angle = r_ang;
    assign nm_clear = r_clr;

    // State, counters, angle realignment register and registered clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_t     <= '0;
            r_ang   <= '0;
            r_clr   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_clr   <= (w_next == S_CLEAR);
            r_ang   <= w_nm_win ? ang_mid : 2'd0;
            if (w_next != r_state)
                r_t <= '0;
            else
                r_t <= r_t + T_ONE;
            if (r_state == S_IDLE)
                r_row <= '0;
            else if (r_state == S_TOP && w_next == S_ROW)
                r_row <= ADDR_W'(1);
            else if (r_state == S_CLEAR && w_next == S_ROW)
                r_row <= r_row + ADDR_W'(1);
        end
    end

    // Next-state decode and all datapath strobes.
    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_row    = '0;
        rd_col    = '0;
        nm_enable = 1'b0;
        nm_pixel0 = '0;
        nm_pixel1 = '0;
        nm_pixel2 = '0;
        wr_en     = 1'b0;
        wr_row    = '0;
        wr_col    = '0;
        wr_data   = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_TOP;
            end
            S_TOP: begin
                busy   = 1'b1;
                wr_en  = 1'b1;
                wr_col = w_tcol;
                if (r_t == T_LASTCOL) w_next = S_ROW;
            end
            S_ROW: begin
                busy = 1'b1;
                if (r_t < T_W) begin
                    rd_en  = 1'b1;
                    rd_row = r_row;
                    rd_col = w_tcol;
                end
                if (w_nm_win) begin
                    nm_enable = 1'b1;
                    nm_pixel0 = mag_up;
                    nm_pixel1 = mag_mid;
                    nm_pixel2 = mag_dn;
                end
                if (r_t >= T_WR0) begin
                    wr_en   = 1'b1;
                    wr_row  = r_row;
                    wr_col  = w_wcol;
                    wr_data = w_border ? '0 : nm_pixel_out;
                end
                if (r_t == T_ROWEND) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                busy   = 1'b1;
                w_next = (r_row < ROW_LAST) ? S_ROW : S_BOT;
            end
            S_BOT: begin
                busy   = 1'b1;
                wr_en  = 1'b1;
                wr_row = ROW_BOT;
                wr_col = w_tcol;
                if (r_t == T_LASTCOL) w_next = S_FIN;
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_nms_row_scheduler.sv
// Directed bench for nms_row_scheduler on an 8x4 image: a gradient buffer
// model, a small NMS unit model, and a write scoreboard.
module tb_nms_row_scheduler;

    localparam int B  = 5;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, rd_en, nm_enable, nm_clear, wr_en;
    logic [AW-1:0] rd_row, rd_col, wr_row, wr_col;
    logic [B-1:0]  mag_up, mag_mid, mag_dn;
    logic [1:0]    ang_mid, nm_angle;
    logic [B-1:0]  nm_pixel0, nm_pixel1, nm_pixel2, nm_pixel_out, wr_data;

    nms_row_scheduler #(.BIT_LENGTH(B), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .mag_up(mag_up), .mag_mid(mag_mid), .mag_dn(mag_dn), .ang_mid(ang_mid),
        .nm_enable(nm_enable), .nm_pixel0(nm_pixel0), .nm_pixel1(nm_pixel1),
        .nm_pixel2(nm_pixel2), .nm_angle(nm_angle), .nm_clear(nm_clear),
        .nm_pixel_out(nm_pixel_out), .wr_en(wr_en), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus patterns, constant per column across rows.
    // mode 0: horizontal ridge; mode 1: angle alignment; mode 2: all 31.
    int mode = 0;

    function automatic logic [B-1:0] f_mid(input int m, input int c);
        if (m == 0) return 5'd20;
        if (m == 1) return (c == 4) ? 5'd15 : 5'd9;
        return 5'd31;
    endfunction

    function automatic logic [B-1:0] f_ud(input int m);
        if (m == 0) return 5'd3;
        if (m == 1) return 5'd20;
        return 5'd31;
    endfunction

    function automatic logic [1:0] f_ang(input int m, input int c);
        if (m == 0) return 2'd2;
        if (m == 1) return (c == 5) ? 2'd2 : 2'd0;
        return 2'd0;
    endfunction

    // Hand-derived expected edge buffer contents.
    function automatic int exp_px(input int m, input int r, input int c);
        if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
        if (m == 0) return 20;
        if (m == 1) begin
            if (c == 4) return 15;
            if (c == 3 || c == 5) return 0;
            return 9;
        end
        return 31;
    endfunction

    // Gradient buffer: one-cycle read latency.
    logic [AW-1:0] g_col = '0;
    always @(posedge clk) if (rd_en) g_col <= rd_col;
    assign mag_up  = f_ud(mode);
    assign mag_dn  = f_ud(mode);
    assign mag_mid = f_mid(mode, int'(g_col));
    assign ang_mid = f_ang(mode, int'(g_col));

    // NMS unit: 2-column history plus incoming column, result registered
    // twice, so column j fed at t=j+1 with angle at t=j+2 emerges at t=j+4.
    logic [B-1:0] c0u, c0m, c0d, c1u, c1m, c1d, q1, q2, n_res;
    logic [B-1:0] n_a, n_b;
    wire nrst = reset | nm_clear;
    always_comb begin
        case (nm_angle)
            2'd0:    begin n_a = c1m; n_b = nm_pixel1; end
            2'd1:    begin n_a = c1u; n_b = nm_pixel2; end
            2'd2:    begin n_a = c0u; n_b = c0d;       end
            default: begin n_a = c1d; n_b = nm_pixel0; end
        endcase
        n_res = (c0m >= n_a && c0m >= n_b) ? c0m : '0;
    end
    always @(posedge clk or posedge nrst) begin
        if (nrst) begin
            c0u <= '0; c0m <= '0; c0d <= '0;
            c1u <= '0; c1m <= '0; c1d <= '0;
            q1  <= '0; q2  <= '0;
        end else begin
            c1u <= c0u; c1m <= c0m; c1d <= c0d;
            c0u <= nm_pixel0; c0m <= nm_pixel1; c0d <= nm_pixel2;
            q1  <= n_res; q2 <= q1;
        end
    end
    assign nm_pixel_out = q2;

    // Scoreboard with cumulative counters; tests look at deltas.
    int frm = 0;
    int got_px [H][W];
    int stamp  [H][W];
    int nwr = 0, ndup = 0, noor = 0, nclr_hi = 0, nclr_rise = 0, novl = 0, ndone = 0;
    logic clr_q = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                nwr++;
                if (int'(wr_row) >= H || int'(wr_col) >= W) noor++;
                else begin
                    if (stamp[wr_row][wr_col] == frm) ndup++;
                    stamp[wr_row][wr_col] = frm;
                    got_px[wr_row][wr_col] = int'(wr_data);
                end
            end
            if (nm_clear) nclr_hi++;
            if (nm_clear && !clr_q) nclr_rise++;
            if (nm_clear && nm_enable) novl++;
            if (done) ndone++;
            clr_q = nm_clear;
        end
    end

    wire [47:0] w_outs = {busy, done, rd_en, nm_enable, nm_clear, wr_en,
                          rd_row, rd_col, wr_row, wr_col, wr_data,
                          nm_pixel0, nm_pixel1, nm_pixel2, nm_angle};

    // Full frame; length counts the start cycle through the done cycle.
    task automatic run_frame(input int m, input bit restart);
        int len, s_wr, s_dup, s_oor, s_chi, s_cri, s_ovl;
        frm++;
        mode = m;
        s_wr = nwr; s_dup = ndup; s_oor = noor;
        s_chi = nclr_hi; s_cri = nclr_rise; s_ovl = novl;
        @(negedge clk);
        start = 1'b1;
        len = 1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            len++;
            start = restart && (len == 20);
            if (len == 2) chk("busy_rise", 64'(busy), 64'd1);
            if (done) break;
        end
        start = 1'b0;
        chk("frame_len", 64'(len), 64'd44);
        chk("busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        chk("done_1cyc", 64'(done), 64'd0);
        chk("n_writes", 64'(nwr - s_wr), 64'(W*H));
        chk("dup_writes", 64'(ndup - s_dup), 64'd0);
        chk("oor_writes", 64'(noor - s_oor), 64'd0);
        chk("clr_cycles", 64'(nclr_hi - s_chi), 64'(H-2));
        chk("clr_pulses", 64'(nclr_rise - s_cri), 64'(H-2));
        chk("clr_vs_en", 64'(novl - s_ovl), 64'd0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                chk($sformatf("px m%0d r%0d c%0d", m, r, c),
                    64'(got_px[r][c]), 64'(exp_px(m, r, c)));
    endtask

    initial begin
        int s_done;
        bit hit;
        repeat (3) @(negedge clk);
        chk("rst_outs", 64'(w_outs), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outs", 64'(w_outs), 64'd0);

        run_frame(0, 1'b1);   // ridge, with an ignored second start
        run_frame(2, 1'b0);   // border zeroing

        // Abort mid-row: reset while reading row 1, column 5.
        frm++;
        mode = 1;
        s_done = ndone;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (rd_en && rd_row == 5'd1 && rd_col == 5'd5) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        chk("abort_reach", 64'(hit), 64'd1);
        reset = 1'b1;
        #1;
        chk("abort_outs", 64'(w_outs), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_nodone", 64'(ndone - s_done), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);

        run_frame(1, 1'b0);   // angle alignment after abort

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nms_row_scheduler.md
Name: nms_row_scheduler

Overview:
- Sequences the non-maximum-suppression (NMS) datapath across a full IMG_W x IMG_H gradient image for the Canny edge pipeline.
- Reads three magnitude rows plus the centre-row angle, one column per cycle, from the gradient buffer and streams them into the NMS unit.
- Delays the angle to match the NMS internal alignment, captures the suppressed output and writes it to the edge buffer.
- Zeroes the image border and clears the NMS unit between rows, because the NMS unit only returns to its load state through reset.

Parameters:
- BIT_LENGTH, 5, pixel/magnitude width.
- IMG_W, 32, image width in columns (>= 4).
- IMG_H, 32, image height in rows (>= 3).
- ADDR_W, 5, row/column index width; must satisfy 2^ADDR_W >= max(IMG_W, IMG_H).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last write of the frame.
- rd_en  out  1  gradient buffer read strobe.
- rd_row  out  ADDR_W  centre row of the read.
- rd_col  out  ADDR_W  column of the read.
- mag_up  in  BIT_LENGTH  magnitude at (rd_row-1, rd_col); valid 1 cycle after rd_en.
- mag_mid  in  BIT_LENGTH  magnitude at (rd_row, rd_col); valid 1 cycle after rd_en.
- mag_dn  in  BIT_LENGTH  magnitude at (rd_row+1, rd_col); valid 1 cycle after rd_en.
- ang_mid  in  2  quantised angle at (rd_row, rd_col); valid 1 cycle after rd_en.
- nm_enable  out  1  NMS operate enable.
- nm_pixel0/1/2  out  BIT_LENGTH each  NMS column inputs (up/mid/dn).
- nm_angle  out  2  NMS angle input.
- nm_clear  out  1  registered NMS clear; OR-ed with reset at the NMS reset pin.
- nm_pixel_out  in  BIT_LENGTH  NMS result.
- wr_en  out  1  edge buffer write strobe.
- wr_row  out  ADDR_W  write row.
- wr_col  out  ADDR_W  write column.
- wr_data  out  BIT_LENGTH  write data.

Behaviour:
- Reset: state IDLE; every output 0, including busy, done, rd_en, nm_enable, nm_clear and wr_en. Reset mid-frame aborts the frame with no done pulse.
- States: IDLE, TOP, ROW, CLEAR, BOT, FIN.
- IDLE: start=1 -> TOP. start is ignored in all other states.
- TOP: writes row 0, data 0, cols 0..IMG_W-1 on consecutive cycles -> ROW with r=1.
- ROW (centre row r): let t=0 be the first ROW cycle.
  - t=0..IMG_W-1: rd_en=1, rd_row=r, rd_col=t.
  - t=1..IMG_W: nm_enable=1; nm_pixel0/1/2 = mag_up/mid/dn passed through combinationally.
  - nm_angle = ang_mid registered once, so the angle of column j is presented at t=j+2.
  - t=j+4 for j=0..IMG_W-1: wr_en=1, wr_row=r, wr_col=j, wr_data=nm_pixel_out.
  - wr_data is forced 0 for j=0 and j=IMG_W-1.
  - nm_enable and nm_pixel inputs are 0 outside t=1..IMG_W.
  - After the t=IMG_W+3 write -> CLEAR.
- CLEAR: nm_clear=1 for exactly 1 cycle.
  - r<IMG_H-2: r+1 and back to ROW.
  - Otherwise -> BOT.
- Each row takes IMG_W+5 cycles; nm_clear is never high while nm_enable is high.
- BOT: writes row IMG_H-1 with zeros, same pattern as TOP -> FIN.
- FIN: done=1 for 1 cycle, busy falls in the same cycle -> IDLE.
- Row and column counters wrap only by explicit reset to 0 at row/frame boundaries. No write ever exceeds IMG_W-1 / IMG_H-1.
- Total frame length from start: 2*IMG_W + (IMG_H-2)*(IMG_W+5) + 2 cycles.

Test Plan:
- Reset mid-ROW (IMG_W=8, IMG_H=4): assert reset at row 1, t=5 -> all outputs 0 immediately. A later start runs a full frame correctly.
- Frame length (IMG_W=8, IMG_H=4): start pulse -> done exactly 2*8 + 2*13 + 2 = 44 cycles later. 32 writes total, one per (row, col), with no duplicates.
- Horizontal ridge: mag_mid=20, mag_up=mag_dn=3, ang_mid=2 everywhere -> interior writes 20; border writes 0.
- Angle alignment: one column j=4 set to 15 and neighbours set to 9, ang=0 everywhere except column 5 ang=2 -> (r,4)=15 and (r,5)=0. Catches off-by-one in the angle delay.
- Border zeroing: all magnitudes 31 -> rows 0 and IMG_H-1, and cols 0 and IMG_W-1, all written 0; interior written 31.
- start during busy, plus nm_clear timing: a second start pulse mid-frame is ignored with no restart. nm_clear pulses IMG_H-2 times, each 1 cycle, each outside nm_enable windows.
